// File: rtl/data_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// dm_pkg: shared definitions for the data memory responder.
//
// Contents:
//   state_t      - responder FSM states (IDLE, WAIT, RESP)
//   WORD_W       - data word width in bits
//   BYTE_OFF_W   - number of byte-offset bits below the word index
//   is_bad_addr  - flags a misaligned or out-of-range byte address
// ----------------------------------------------------------------------------
package dm_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // An access is bad if it is not word aligned or its word index falls
  // outside the array. The full upper address is compared, so aliasing
  // through truncated index bits can never slip past this check.
  function automatic logic is_bad_addr(input logic [WORD_W-1:0] addr,
                                       input int unsigned       depth);
    logic [WORD_W-1:0] word_idx;
    word_idx = {{BYTE_OFF_W{1'b0}}, addr[WORD_W-1:BYTE_OFF_W]};
    return (addr[BYTE_OFF_W-1:0] != '0) || (word_idx >= depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if: MEM-stage data port between the CPU (master) and the
// memory responder (slave).
//
// Signals:
//   req_i    master->slave  request, held until ready_o is seen
//   we_i     master->slave  1 = store, 0 = load
//   addr_i   master->slave  byte address
//   wdata_i  master->slave  store data
//   rdata_o  slave->master  load data, valid with ready_o, held afterwards
//   ready_o  slave->master  one-cycle response pulse
//   err_o    slave->master  misaligned / out-of-range flag, valid with ready_o
//   stall_o  slave->master  pipeline freeze while a request is outstanding
//   busy_o   slave->master  responder is not idle
// ----------------------------------------------------------------------------
interface data_mem_responder_if;
  import dm_pkg::*;

  logic              req_i;
  logic              we_i;
  logic [WORD_W-1:0] addr_i;
  logic [WORD_W-1:0] wdata_i;
  logic [WORD_W-1:0] rdata_o;
  logic              ready_o;
  logic              err_o;
  logic              stall_o;
  logic              busy_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  rdata_o, ready_o, err_o, stall_o, busy_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output rdata_o, ready_o, err_o, stall_o, busy_o
  );

endinterface

// File: rtl/data_mem_responder_word_array.sv
// ----------------------------------------------------------------------------
// dm_word_array: DEPTH x WORD_W storage with one synchronous write port and
// one asynchronous read port.
//
// Ports:
//   clk_i  clock; write happens on the rising edge
//   we     write enable
//   waddr  write word index
//   wdata  write data
//   raddr  read word index
//   rdata  read data (combinational from raddr)
// ----------------------------------------------------------------------------
module dm_word_array
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; clearing DEPTH words would need a
  // multi-cycle sweep or a huge reset fan-out, and contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder: slow data memory for the CPU MEM stage.
//
// Accepts one load/store at a time, waits LATENCY cycles, then answers with a
// one-cycle ready pulse. Misaligned or out-of-range accesses answer at once
// with err_o set, return zero and write nothing.
//
// Parameters:
//   DEPTH    number of 32-bit words (word index 0..DEPTH-1)
//   LATENCY  wait cycles between acceptance and response (0 allowed)
//
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset; aborts any transaction in flight
//   bus    slave side of data_mem_responder_if
// ----------------------------------------------------------------------------
module data_mem_responder
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned CNT_W    = (LATENCY == 0) ? 1 : $clog2(LATENCY + 1);
  localparam int unsigned IDX_W    = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
  localparam bit          ZERO_LAT = (LATENCY == 0);
  // The load value is only used when LATENCY > 0; the guard keeps the
  // expression well defined for the zero-latency build.
  localparam logic [CNT_W-1:0] CNT_LOAD =
    ZERO_LAT ? '0 : CNT_W'(LATENCY - 1);

  // FSM and counter
  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Request captured at acceptance, replayed when the wait expires
  logic              cap_we;
  logic              cap_bad;
  logic [IDX_W-1:0]  cap_idx;
  logic [WORD_W-1:0] cap_wdata;

  // Registered response outputs
  logic [WORD_W-1:0] rdata_q;
  logic              ready_q;
  logic              err_q;

  // Live decode of the request on the bus
  logic             live_bad;
  logic [IDX_W-1:0] live_idx;

  assign live_bad = is_bad_addr(bus.addr_i, DEPTH);
  assign live_idx = bus.addr_i[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];

  // The edge that enters RESP performs the access. Coming straight from IDLE
  // (bad address or zero latency) the request has not been captured yet, so
  // the live bus fields are used; from WAIT the captured copy is used.
  logic              go_resp;
  logic              cur_we;
  logic              cur_bad;
  logic [IDX_W-1:0]  cur_idx;
  logic [WORD_W-1:0] cur_wdata;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    go_resp   = 1'b0;
    cur_we    = cap_we;
    cur_bad   = cap_bad;
    cur_idx   = cap_idx;
    cur_wdata = cap_wdata;
    case (state)
      IDLE: begin
        go_resp   = bus.req_i & (live_bad | ZERO_LAT);
        cur_we    = bus.we_i;
        cur_bad   = live_bad;
        cur_idx   = live_idx;
        cur_wdata = bus.wdata_i;
      end
      WAIT:    go_resp = (cnt == '0);
      default: go_resp = 1'b0;
    endcase
  end

  // Reset wins over a commit on the same edge, so an aborted store is lost.
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  assign mem_we = go_resp & ~rst_i & cur_we & ~cur_bad;

  dm_word_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (IDX_W)
  ) u_word_array (
    .clk_i (clk_i),
    .we    (mem_we),
    .waddr (cur_idx),
    .wdata (cur_wdata),
    .raddr (cur_idx),
    .rdata (mem_rdata)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= go_resp;
      err_q   <= go_resp & cur_bad;
      // Stores and bad accesses answer with zero; rdata holds between responses.
      if (go_resp) begin
        rdata_q <= (cur_we | cur_bad) ? '0 : mem_rdata;
      end

      case (state)
        IDLE: begin
          if (bus.req_i) begin
            cap_we    <= bus.we_i;
            cap_bad   <= live_bad;
            cap_idx   <= live_idx;
            cap_wdata <= bus.wdata_i;
            if (go_resp) begin
              state <= RESP;
            end else begin
              cnt   <= CNT_LOAD;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        // One response cycle, then back to IDLE so responses never abut.
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rdata_o = rdata_q;
  assign bus.ready_o = ready_q;
  assign bus.err_o   = err_q;
  assign bus.busy_o  = (state != IDLE);
  assign bus.stall_o = bus.req_i & ~ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder: directed test of data_mem_responder with a
// LATENCY=2 instance (dut2) and a LATENCY=0 instance (dut0), DEPTH=128.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus2 ();

  data_mem_responder #(.DEPTH(128), .LATENCY(0)) dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus0)
  );

  data_mem_responder #(.DEPTH(128), .LATENCY(2)) dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // sel 0 selects the LATENCY=0 instance, anything else the LATENCY=2 one.
  task automatic drive(input int sel, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel == 0) begin
      bus0.req_i = req; bus0.we_i = we; bus0.addr_i = addr; bus0.wdata_i = wdata;
    end else begin
      bus2.req_i = req; bus2.we_i = we; bus2.addr_i = addr; bus2.wdata_i = wdata;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bus0.ready_o : bus2.ready_o;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? bus0.err_o : bus2.err_o;
  endfunction
  function automatic logic get_stall(input int sel);
    return (sel == 0) ? bus0.stall_o : bus2.stall_o;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? bus0.busy_o : bus2.busy_o;
  endfunction
  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? bus0.rdata_o : bus2.rdata_o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from IDLE; called just after a clock edge.
  // Response is expected exp_lat+1 cycles after the acceptance cycle.
  task automatic xact(input int sel, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input int exp_lat,
                      input logic exp_err, input logic [31:0] exp_rd,
                      input string tag);
    int cyc;
    bit seen;
    drive(sel, 1'b1, we, addr, wdata);
    #1;
    check({tag, ":stall_c0"}, 32'(get_stall(sel)), 32'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      step();
      cyc++;
      if (get_ready(sel)) seen = 1'b1;
      else check({tag, ":stall_wait"}, 32'(get_stall(sel)), 32'd1);
    end
    check({tag, ":ready_seen"}, 32'(seen), 32'd1);
    check({tag, ":latency"}, cyc, 32'(exp_lat + 1));
    check({tag, ":err"}, 32'(get_err(sel)), 32'(exp_err));
    check({tag, ":rdata"}, get_rdata(sel), exp_rd);
    check({tag, ":stall_resp"}, 32'(get_stall(sel)), 32'd0);
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check({tag, ":ready_1cyc"}, 32'(get_ready(sel)), 32'd0);
    check({tag, ":busy_idle"}, 32'(get_busy(sel)), 32'd0);
  endtask

  initial begin
    int cyc;
    int gap;
    int pulses;

    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();

    // Reset state
    for (int s = 0; s <= 2; s += 2) begin
      check($sformatf("rst%0d:ready", s), 32'(get_ready(s)), 32'd0);
      check($sformatf("rst%0d:err",   s), 32'(get_err(s)),   32'd0);
      check($sformatf("rst%0d:rdata", s), get_rdata(s),      32'd0);
      check($sformatf("rst%0d:busy",  s), 32'(get_busy(s)),  32'd0);
      check($sformatf("rst%0d:stall", s), 32'(get_stall(s)), 32'd0);
    end
    rst = 1'b0;
    step();

    // Store then load, LATENCY=2
    xact(2, 1'b1, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0,        "st10");
    xact(2, 1'b0, 32'h10, 32'h0,        2, 1'b0, 32'hDEADBEEF, "ld10");

    // LATENCY=0 instance
    xact(0, 1'b1, 32'h0, 32'h12345678, 0, 1'b0, 32'h0,        "z_st0");
    xact(0, 1'b0, 32'h0, 32'h0,        0, 1'b0, 32'h12345678, "z_ld0");

    // Misaligned store answers immediately and leaves memory untouched
    xact(2, 1'b1, 32'h13, 32'hFFFFFFFF, 0, 1'b1, 32'h0,        "mis13");
    xact(2, 1'b0, 32'h10, 32'h0,        2, 1'b0, 32'hDEADBEEF, "ld10b");

    // Out-of-range load (word 128) returns zero with err
    xact(2, 1'b0, 32'h200, 32'h0, 0, 1'b1, 32'h0, "oor200");

    // Last legal word
    xact(2, 1'b1, 32'h1FC, 32'hCAFEF00D, 2, 1'b0, 32'h0,        "st1fc");
    xact(2, 1'b0, 32'h1FC, 32'h0,        2, 1'b0, 32'hCAFEF00D, "ld1fc");

    // Reset in the first WAIT cycle drops the pending store
    xact(2, 1'b1, 32'h20, 32'h11111111, 2, 1'b0, 32'h0, "st20old");
    drive(2, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
    step();
    check("abort:busy_wait", 32'(get_busy(2)), 32'd1);
    rst = 1'b1;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check("abort:busy_after", 32'(get_busy(2)), 32'd0);
    check("abort:ready_after", 32'(get_ready(2)), 32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (get_ready(2)) pulses++;
    end
    check("abort:no_pulse", pulses, 32'd0);
    xact(2, 1'b0, 32'h20, 32'h0, 2, 1'b0, 32'h11111111, "ld20");

    // Back-to-back loads with req held high
    xact(2, 1'b1, 32'h40, 32'h0BADF00D, 2, 1'b0, 32'h0, "st40");
    xact(2, 1'b1, 32'h44, 32'h600DCAFE, 2, 1'b0, 32'h0, "st44");
    drive(2, 1'b1, 1'b0, 32'h40, 32'h0);
    step();
    // Bus changes during WAIT must be ignored, including this stray store
    drive(2, 1'b1, 1'b1, 32'h44, 32'hFFFFFFFF);
    cyc = 1;
    while (!get_ready(2) && cyc < 20) begin
      step();
      cyc++;
    end
    check("b2b1:latency", cyc, 32'd3);
    check("b2b1:rdata", get_rdata(2), 32'h0BADF00D);
    check("b2b1:stall_resp", 32'(get_stall(2)), 32'd0);
    drive(2, 1'b1, 1'b0, 32'h44, 32'h0);
    gap = 0;
    step();
    while (!get_ready(2) && gap < 20) begin
      gap++;
      if (gap == 2) drive(2, 1'b1, 1'b0, 32'h40, 32'h0);
      step();
    end
    check("b2b2:gap", gap, 32'd3);
    check("b2b2:rdata", get_rdata(2), 32'h600DCAFE);
    check("b2b2:err", 32'(get_err(2)), 32'd0);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check("b2b2:ready_1cyc", 32'(get_ready(2)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
